// File: rtl/alu_exec_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_exec_unit                                                    |
// | Brief   : Handshaked ALU executing ALUControl codes; results held until    |
// |           taken. Optional serial shifter enabled by macro ALU_SHIFT_EN.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_AND = 3'b010;
  localparam logic [2:0] c_OP_OR  = 3'b011;
  localparam logic [2:0] c_OP_SLL = 3'b100;
  localparam logic [2:0] c_OP_SLT = 3'b101;
  localparam logic [2:0] c_OP_SRL = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  generate
    if (SHAMT_W != $clog2(WIDTH)) begin : g_bad_shamt_w
      $error("SHAMT_W must equal clog2(WIDTH)");
    end
  endgenerate

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_illegal;
  logic             w_accept;
  logic [WIDTH-1:0] w_alu_result;
  logic             w_alu_illegal;
  logic             w_start_busy;

`ifdef ALU_SHIFT_EN
  logic [SHAMT_W-1:0] r_count;
  logic               r_dir_left;
  logic [SHAMT_W-1:0] w_shamt;
  logic               w_is_shift;
  logic [WIDTH-1:0]   w_shift_result;

  assign w_shamt        = src_b[SHAMT_W-1:0];
  assign w_is_shift     = (ALUControl == c_OP_SLL) || (ALUControl == c_OP_SRL);
  assign w_start_busy   = w_is_shift && (w_shamt != '0);
  assign w_shift_result = r_dir_left ? (r_result << 1) : (r_result >> 1);
`else
  assign w_start_busy = 1'b0;
`endif

  assign w_accept  = in_valid && (r_state == S_IDLE);
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

  // Single-cycle part of the ALU; shifts only load src_a here and finish in BUSY.
  always_comb begin
    w_alu_result  = '0;
    w_alu_illegal = 1'b0;
    case (ALUControl)
      c_OP_ADD: w_alu_result = src_a + src_b;
      c_OP_SUB: w_alu_result = src_a - src_b;
      c_OP_AND: w_alu_result = src_a & src_b;
      c_OP_OR:  w_alu_result = src_a | src_b;
      c_OP_SLT: w_alu_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
`ifdef ALU_SHIFT_EN
      c_OP_SLL,
      c_OP_SRL: w_alu_result = src_a;
`else
      c_OP_SLL,
      c_OP_SRL: w_alu_illegal = 1'b1;
`endif
      default:  w_alu_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_start_busy ? S_BUSY : S_DONE;
        end
      end
`ifdef ALU_SHIFT_EN
      S_BUSY: begin
        if (r_count == SHAMT_W'(1)) begin
          w_state_nxt = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result   <= '0;
      r_zero     <= 1'b1;
      r_illegal  <= 1'b0;
`ifdef ALU_SHIFT_EN
      r_count    <= '0;
      r_dir_left <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_result   <= w_alu_result;
            r_zero     <= (w_alu_result == '0);
            r_illegal  <= w_alu_illegal;
`ifdef ALU_SHIFT_EN
            r_count    <= w_shamt;
            r_dir_left <= (ALUControl == c_OP_SLL);
`endif
          end
        end
`ifdef ALU_SHIFT_EN
        S_BUSY: begin
          r_result <= w_shift_result;
          r_zero   <= (w_shift_result == '0);
          r_count  <= r_count - SHAMT_W'(1);
        end
`endif
        default: begin
          r_result <= r_result;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_alu_exec_unit                                                 |
// | Brief   : Directed self-checking bench for alu_exec_unit.                  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_alu_exec_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ALUControl;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int tests;
  int fails;

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUControl (ALUControl),
    .src_a      (src_a),
    .src_b      (src_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op and return cycles from accept edge to out_valid (200 = timeout).
  task automatic run_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    ALUControl = code;
    src_a      = a;
    src_b      = b;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    tests++;
    if ({in_ready, out_valid, result, zero, illegal} !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_state got rdy=%b vld=%b res=%h z=%b ill=%b want rdy=1 vld=0 res=0 z=1 ill=0",
               in_ready, out_valid, result, zero, illegal);
    end
  endtask

  task automatic test_arith();
    int lat;
    run_op(3'b000, 32'h7FFF_FFFF, 32'h1, lat);
    tests++;
    if (lat !== 1) begin fails++; $display("FAIL add_latency got %0d want 1", lat); end
    tests++;
    if ({result, zero, illegal} !== {32'h8000_0000, 1'b0, 1'b0}) begin
      fails++; $display("FAIL add_result got %h z=%b ill=%b want 80000000 z=0 ill=0", result, zero, illegal);
    end
    release_result();

    run_op(3'b001, 32'd5, 32'd5, lat);
    tests++;
    if ({lat[7:0], result, zero} !== {8'd1, 32'h0, 1'b1}) begin
      fails++; $display("FAIL sub_zero got lat=%0d res=%h z=%b want lat=1 res=0 z=1", lat, result, zero);
    end
    release_result();

    run_op(3'b001, 32'd0, 32'd1, lat);
    tests++;
    if ({result, zero} !== {32'hFFFF_FFFF, 1'b0}) begin
      fails++; $display("FAIL sub_wrap got %h z=%b want ffffffff z=0", result, zero);
    end
    release_result();

    run_op(3'b101, 32'hFFFF_FFFF, 32'd1, lat);
    tests++;
    if ({result, zero} !== {32'h1, 1'b0}) begin
      fails++; $display("FAIL slt_neg got %h z=%b want 00000001 z=0", result, zero);
    end
    release_result();

    run_op(3'b101, 32'd1, 32'hFFFF_FFFF, lat);
    tests++;
    if ({result, zero} !== {32'h0, 1'b1}) begin
      fails++; $display("FAIL slt_pos got %h z=%b want 00000000 z=1", result, zero);
    end
    release_result();
  endtask

  task automatic test_logic();
    int lat;
    run_op(3'b010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, lat);
    tests++;
    if (result !== 32'h00F0_00F0) begin fails++; $display("FAIL and got %h want 00f000f0", result); end
    release_result();

    run_op(3'b011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, lat);
    tests++;
    if (result !== 32'hFFF0_FFF0) begin fails++; $display("FAIL or got %h want fff0fff0", result); end
    release_result();

    run_op(3'b111, 32'h1234_5678, 32'h1, lat);
    tests++;
    if ({lat[7:0], result, zero, illegal} !== {8'd1, 32'h0, 1'b1, 1'b1}) begin
      fails++; $display("FAIL rsvd_code got lat=%0d res=%h z=%b ill=%b want lat=1 res=0 z=1 ill=1",
                        lat, result, zero, illegal);
    end
    release_result();
  endtask

  task automatic test_hold();
    int lat;
    int bad;
    run_op(3'b000, 32'd10, 32'd20, lat);
    bad = 0;
    ALUControl = 3'b001;
    src_a      = 32'hDEAD_BEEF;
    src_b      = 32'h1;
    in_valid   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if ({out_valid, in_ready, result, zero} !== {1'b1, 1'b0, 32'd30, 1'b0}) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++; $display("FAIL hold_stable got %0d bad cycles (vld=%b rdy=%b res=%h) want 0", bad,
                        out_valid, in_ready, result);
    end
    in_valid = 1'b0;
    release_result();
    tests++;
    if ({in_ready, out_valid, result} !== {1'b1, 1'b0, 32'd30}) begin
      fails++; $display("FAIL hold_release got rdy=%b vld=%b res=%h want rdy=1 vld=0 res=0000001e",
                        in_ready, out_valid, result);
    end
  endtask

  task automatic test_shift();
    int lat;
`ifdef ALU_SHIFT_EN
    run_op(3'b100, 32'h1, 32'd31, lat);
    tests++;
    if ({lat[7:0], result, zero, illegal} !== {8'd32, 32'h8000_0000, 1'b0, 1'b0}) begin
      fails++; $display("FAIL sll31 got lat=%0d res=%h z=%b ill=%b want lat=32 res=80000000 z=0 ill=0",
                        lat, result, zero, illegal);
    end
    release_result();

    run_op(3'b110, 32'h8000_0000, 32'd0, lat);
    tests++;
    if ({lat[7:0], result} !== {8'd1, 32'h8000_0000}) begin
      fails++; $display("FAIL srl0 got lat=%0d res=%h want lat=1 res=80000000", lat, result);
    end
    release_result();

    run_op(3'b110, 32'hF000_0000, 32'hFFFF_FFE4, lat);
    tests++;
    if ({lat[7:0], result, zero} !== {8'd5, 32'h0F00_0000, 1'b0}) begin
      fails++; $display("FAIL srl4 got lat=%0d res=%h z=%b want lat=5 res=0f000000 z=0", lat, result, zero);
    end
    release_result();

    run_op(3'b110, 32'h1, 32'd1, lat);
    tests++;
    if ({lat[7:0], result, zero} !== {8'd2, 32'h0, 1'b1}) begin
      fails++; $display("FAIL srl_to_zero got lat=%0d res=%h z=%b want lat=2 res=0 z=1", lat, result, zero);
    end
    release_result();
`else
    run_op(3'b100, 32'h1, 32'd31, lat);
    tests++;
    if ({lat[7:0], result, zero, illegal} !== {8'd1, 32'h0, 1'b1, 1'b1}) begin
      fails++; $display("FAIL sll_absent got lat=%0d res=%h z=%b ill=%b want lat=1 res=0 z=1 ill=1",
                        lat, result, zero, illegal);
    end
    release_result();

    run_op(3'b110, 32'h8000_0000, 32'd4, lat);
    tests++;
    if ({lat[7:0], result, zero, illegal} !== {8'd1, 32'h0, 1'b1, 1'b1}) begin
      fails++; $display("FAIL srl_absent got lat=%0d res=%h z=%b ill=%b want lat=1 res=0 z=1 ill=1",
                        lat, result, zero, illegal);
    end
    release_result();
`endif
  endtask

  task automatic test_reset_mid_op();
    int lat;
    int seen;
    ALUControl = 3'b110;
    src_a      = 32'hFFFF_FFFF;
    src_b      = 32'd20;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL mid_op_busy got rdy=%b want 0", in_ready); end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({in_ready, out_valid, result, zero, illegal} !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0}) begin
      fails++; $display("FAIL async_reset got rdy=%b vld=%b res=%h z=%b ill=%b want rdy=1 vld=0 res=0 z=1 ill=0",
                        in_ready, out_valid, result, zero, illegal);
    end
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    tests++;
    if (seen !== 0) begin fails++; $display("FAIL no_valid_after_reset got %0d valid cycles want 0", seen); end

    run_op(3'b000, 32'd2, 32'd3, lat);
    tests++;
    if ({lat[7:0], result, zero} !== {8'd1, 32'd5, 1'b0}) begin
      fails++; $display("FAIL add_after_reset got lat=%0d res=%h z=%b want lat=1 res=00000005 z=0", lat, result, zero);
    end
    release_result();
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    ALUControl = 3'b000;
    src_a      = '0;
    src_b      = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_arith();
    test_logic();
    test_hold();
    test_shift();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
